// File: rtl/us_range_pkg.sv
// Shared definitions for the ultrasonic ranging chain: FSM states, default
// timing constants and the clock-divider ratio.
package us_range_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG    = 3'd1,
    WAIT_HI = 3'd2,
    MEAS    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  localparam int DEF_TRIG_US    = 10;
  localparam int DEF_PERIOD_US  = 60000;
  localparam int DEF_TIMEOUT_US = 30000;
  localparam int DEF_US_PER_CM  = 58;

  // 12 MHz reference divided down to the 1 MHz measurement clock
  localparam int CLK_DIV_RATIO  = 12;

endpackage

// File: rtl/us_echo_sync.sv
// Two-flop synchroniser for an asynchronous sensor line, with a third flop
// providing single-cycle rise/fall strobes on the synchronised level.
module us_echo_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic sig_s,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic dly_r;

  // synchroniser chain plus delay stage for edge detection
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      dly_r  <= 1'b0;
    end else begin
      meta_r <= sig_in;
      sync_r <= meta_r;
      dly_r  <= sync_r;
    end
  end

  assign sig_s = sync_r;
  assign rise  = sync_r & ~dly_r;
  assign fall  = ~sync_r & dly_r;

endmodule

// File: rtl/us_range_meter.sv
// Ultrasonic range measurement: periodic trigger, echo width timing and
// divider-free conversion to centimetres, all on the 1 MHz clock.
module us_range_meter
  import us_range_pkg::*;
#(
  parameter int TRIG_US    = DEF_TRIG_US,
  parameter int PERIOD_US  = DEF_PERIOD_US,
  parameter int TIMEOUT_US = DEF_TIMEOUT_US,
  parameter int US_PER_CM  = DEF_US_PER_CM,
  parameter int CNT_W      = 16,
  parameter int DIST_W     = 10
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] distance,
  output logic              valid,
  output logic              timeout,
  output logic              busy
);

  localparam int SUB_W = $clog2(US_PER_CM);

  // worst-case WAIT_HI plus MEAS must finish before the period wraps
  if (TRIG_US + 2 * TIMEOUT_US + 2 >= PERIOD_US) begin : g_bad_period
    $error("us_range_meter: TRIG_US + 2*TIMEOUT_US does not fit in PERIOD_US");
  end
  if (PERIOD_US >= (2 ** CNT_W)) begin : g_bad_cnt_w
    $error("us_range_meter: CNT_W too narrow for PERIOD_US");
  end
  if (TRIG_US < 1 || US_PER_CM < 2) begin : g_bad_consts
    $error("us_range_meter: TRIG_US must be >= 1 and US_PER_CM >= 2");
  end

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    tcnt_r;
  logic [SUB_W-1:0]    sub_r;
  logic [DIST_W-1:0]   cm_r;
  logic [DIST_W-1:0]   distance_r;
  logic                trig_r;
  logic                valid_r;
  logic                timeout_r;
  logic                busy_r;

  logic echo_s;
  logic rise_s;
  logic fall_s;
  logic trig_end_s;
  logic tmo_end_s;
  logic per_end_s;
  logic cnt_clr_s;
  logic meas_clr_s;
  logic count_s;
  logic latch_s;
  logic tmo_s;
  logic tcnt_run_s;

  us_echo_sync u_echo_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .sig_in (echo),
    .sig_s  (echo_s),
    .rise   (rise_s),
    .fall   (fall_s)
  );

  assign trig_end_s = (cnt_r == CNT_W'(TRIG_US - 1));
  assign per_end_s  = (cnt_r == CNT_W'(PERIOD_US - 1));
  assign tmo_end_s  = (tcnt_r == CNT_W'(TIMEOUT_US - 1));

  // state register
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state logic; a fall beats the MEAS timeout by being tested first
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = TRIG;
        else       state_nxt_s = IDLE;
      end
      TRIG: begin
        if (trig_end_s) state_nxt_s = WAIT_HI;
        else            state_nxt_s = TRIG;
      end
      WAIT_HI: begin
        if (rise_s)         state_nxt_s = MEAS;
        else if (tmo_end_s) state_nxt_s = HOLDOFF;
        else                state_nxt_s = WAIT_HI;
      end
      MEAS: begin
        if (fall_s || tmo_end_s) state_nxt_s = HOLDOFF;
        else                     state_nxt_s = MEAS;
      end
      HOLDOFF: begin
        if (!per_end_s) state_nxt_s = HOLDOFF;
        else if (start) state_nxt_s = TRIG;
        else            state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // per-state datapath controls
  always_comb begin
    cnt_clr_s  = 1'b0;
    meas_clr_s = 1'b0;
    count_s    = 1'b0;
    latch_s    = 1'b0;
    tmo_s      = 1'b0;
    tcnt_run_s = 1'b0;
    case (state_r)
      IDLE:    cnt_clr_s = start;
      TRIG:    cnt_clr_s = 1'b0;
      WAIT_HI: begin
        meas_clr_s = rise_s;
        tmo_s      = ~rise_s & tmo_end_s;
        tcnt_run_s = 1'b1;
      end
      MEAS: begin
        latch_s    = fall_s;
        count_s    = echo_s;
        tmo_s      = ~fall_s & tmo_end_s;
        tcnt_run_s = 1'b1;
      end
      HOLDOFF: cnt_clr_s = per_end_s & start;
      default: cnt_clr_s = 1'b0;
    endcase
  end

  // period counter and per-state timeout counter
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_r  <= '0;
      tcnt_r <= '0;
    end else begin
      if (cnt_clr_s)            cnt_r <= '0;
      else if (state_r != IDLE) cnt_r <= cnt_r + CNT_W'(1);
      else                      cnt_r <= cnt_r;

      if (state_nxt_s != state_r) tcnt_r <= '0;
      else if (tcnt_run_s)        tcnt_r <= tcnt_r + CNT_W'(1);
      else                        tcnt_r <= tcnt_r;
    end
  end

  // centimetre accumulation: the rise cycle already has echo_s high, so it
  // is counted by starting sub at one
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sub_r <= '0;
      cm_r  <= '0;
    end else if (meas_clr_s) begin
      sub_r <= SUB_W'(1);
      cm_r  <= '0;
    end else if (count_s) begin
      if (sub_r == SUB_W'(US_PER_CM - 1)) begin
        sub_r <= '0;
        if (cm_r != {DIST_W{1'b1}}) cm_r <= cm_r + DIST_W'(1);
        else                        cm_r <= cm_r;
      end else begin
        sub_r <= sub_r + SUB_W'(1);
      end
    end else begin
      sub_r <= sub_r;
      cm_r  <= cm_r;
    end
  end

  // registered outputs, aligned with the state they describe
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      trig_r     <= 1'b0;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      timeout_r  <= 1'b0;
      distance_r <= '0;
    end else begin
      trig_r  <= (state_nxt_s == TRIG);
      busy_r  <= (state_nxt_s != IDLE);
      valid_r <= latch_s;
      if (latch_s) begin
        distance_r <= cm_r;
        timeout_r  <= 1'b0;
      end else if (tmo_s) begin
        timeout_r  <= 1'b1;
      end else begin
        timeout_r  <= timeout_r;
      end
    end
  end

  assign trig     = trig_r;
  assign busy     = busy_r;
  assign valid    = valid_r;
  assign timeout  = timeout_r;
  assign distance = distance_r;

endmodule

// File: tb/tb_us_range_meter.sv
// Directed bench for us_range_meter: two instances (10-bit and 4-bit distance)
// share stimulus; expected distances go through a scoreboard queue.
module tb_us_range_meter;

  localparam int TRIG = 10;
  localparam int PER  = 3000;
  localparam int TMO  = 1300;
  localparam int UPC  = 58;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       start;
  logic       echo;
  logic       trig_a, valid_a, timeout_a, busy_a;
  logic [9:0] dist_a;
  logic       trig_b, valid_b, timeout_b, busy_b;
  logic [3:0] dist_b;

  int errors  = 0;
  int checks  = 0;
  int cyc_cnt = 0;
  int vcnt    = 0;

  typedef struct {
    int d_a;
    int d_b;
  } exp_t;
  exp_t exp_q[$];

  us_range_meter #(
    .TRIG_US(TRIG), .PERIOD_US(PER), .TIMEOUT_US(TMO),
    .US_PER_CM(UPC), .CNT_W(16), .DIST_W(10)
  ) dut_a (
    .clk_in(clk_in), .rst(rst), .start(start), .echo(echo),
    .trig(trig_a), .distance(dist_a), .valid(valid_a),
    .timeout(timeout_a), .busy(busy_a)
  );

  us_range_meter #(
    .TRIG_US(TRIG), .PERIOD_US(PER), .TIMEOUT_US(TMO),
    .US_PER_CM(UPC), .CNT_W(16), .DIST_W(4)
  ) dut_b (
    .clk_in(clk_in), .rst(rst), .start(start), .echo(echo),
    .trig(trig_b), .distance(dist_b), .valid(valid_b),
    .timeout(timeout_b), .busy(busy_b)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk_in) begin
    if (valid_a === 1'b1) vcnt <= vcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int   k = 0;
    exp_t e;
    do begin
      cyc(1);
      k++;
    end while (valid_a !== 1'b1 && k < 8);
    check({tag, "_valid"}, valid_a, 1);
    check({tag, "_valid_b"}, valid_b, 1);
    check({tag, "_valid_lat"}, (k >= 2 && k <= 3), 1);
    check({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_dist_a"}, dist_a, e.d_a);
      check({tag, "_dist_b"}, dist_b, e.d_b);
    end
    cyc(1);
    check({tag, "_valid_pulse"}, valid_a, 0);
  endtask

  task automatic wait_trig(input string tag, output int t);
    int k = 0;
    while (trig_a !== 1'b1 && k < PER + 50) begin
      cyc(1);
      k++;
    end
    check({tag, "_trig_seen"}, trig_a, 1);
    t = cyc_cnt;
  endtask

  // called at the trig-rise sample of a period
  task automatic measure(input string tag, input int high, input int ea, input int eb);
    cyc(TRIG + 100);
    echo = 1'b1;
    exp_q.push_back('{d_a: ea, d_b: eb});
    cyc(high);
    echo = 1'b0;
    wait_valid(tag);
    check({tag, "_timeout"}, timeout_a, 0);
  endtask

  initial begin
    int t_prev;
    int t_now;
    int k;
    int v0;
    int hits;
    int highs[3] = '{57, 58, 116};
    int dists[3] = '{0, 1, 2};

    rst   = 1'b0;
    start = 1'b0;
    echo  = 1'b0;
    cyc(3);
    check("rst_trig", trig_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_timeout", timeout_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_dist_a", dist_a, 0);
    check("rst_dist_b", dist_b, 0);

    rst = 1'b1;
    cyc(2);
    check("idle_busy", busy_a, 0);

    // first period: trigger width and a 580-cycle echo
    start = 1'b1;
    cyc(1);
    t_prev = cyc_cnt;
    check("trig_first", trig_a, 1);
    check("busy_on", busy_a, 1);
    cyc(TRIG - 1);
    check("trig_last", trig_a, 1);
    cyc(1);
    check("trig_end", trig_a, 0);
    cyc(500);
    echo = 1'b1;
    exp_q.push_back('{d_a: 10, d_b: 10});
    cyc(580);
    echo = 1'b0;
    wait_valid("h580");
    check("h580_timeout", timeout_a, 0);
    wait_trig("p1", t_now);
    check("period_1", t_now - t_prev, PER);
    t_prev = t_now;

    // floor behaviour around the sub-counter wrap
    for (int i = 0; i < 3; i++) begin
      measure($sformatf("h%0d", highs[i]), highs[i], dists[i], dists[i]);
      wait_trig($sformatf("ph%0d", highs[i]), t_now);
      check($sformatf("period_h%0d", highs[i]), t_now - t_prev, PER);
      t_prev = t_now;
    end

    // echo never rises
    v0 = vcnt;
    k  = 0;
    while (timeout_a !== 1'b1 && k < TRIG + TMO + 50) begin
      cyc(1);
      k++;
    end
    check("noecho_tmo_time", cyc_cnt - t_prev, TRIG + TMO);
    check("noecho_timeout_b", timeout_b, 1);
    check("noecho_no_valid", vcnt, v0);
    check("noecho_dist_a_held", dist_a, 2);
    check("noecho_dist_b_held", dist_b, 2);
    wait_trig("pnoecho", t_now);
    check("period_noecho", t_now - t_prev, PER);
    t_prev = t_now;

    measure("h1160", 1160, 20, 15);
    wait_trig("p1160", t_now);
    t_prev = t_now;

    measure("h1200", 1200, 20, 15);
    wait_trig("p1200", t_now);
    t_prev = t_now;

    // echo stuck high past the MEAS timeout
    cyc(TRIG + 100);
    echo = 1'b1;
    v0   = vcnt;
    k    = 0;
    while (timeout_a !== 1'b1 && k < TMO + 50) begin
      cyc(1);
      k++;
    end
    check("stuck_tmo_time", k, TMO + 3);
    check("stuck_timeout_b", timeout_b, 1);
    cyc(1400 - k);
    echo = 1'b0;
    cyc(10);
    check("stuck_no_valid", vcnt, v0);
    check("stuck_dist_a_held", dist_a, 20);
    check("stuck_dist_b_held", dist_b, 15);
    wait_trig("pstuck", t_now);
    check("period_stuck", t_now - t_prev, PER);
    t_prev = t_now;

    // start dropped mid-measurement
    cyc(TRIG + 100);
    echo = 1'b1;
    exp_q.push_back('{d_a: 10, d_b: 10});
    cyc(300);
    start = 1'b0;
    cyc(280);
    echo = 1'b0;
    wait_valid("drop");
    check("drop_timeout_clr", timeout_a, 0);
    k    = 0;
    hits = 0;
    while (busy_a !== 1'b0 && k < PER) begin
      cyc(1);
      k++;
      if (trig_a === 1'b1) hits++;
    end
    check("drop_idle_time", cyc_cnt - t_prev, PER);
    for (int i = 0; i < 200; i++) begin
      cyc(1);
      if (trig_a === 1'b1) hits++;
    end
    check("drop_no_trig", hits, 0);
    check("drop_idle_busy", busy_a, 0);

    // asynchronous reset while the trigger is high
    start = 1'b1;
    cyc(1);
    check("rst_mid_trig_before", trig_a, 1);
    cyc(3);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_trig_a", trig_a, 0);
    check("rst_mid_trig_b", trig_b, 0);
    check("rst_mid_busy", busy_a, 0);
    check("rst_mid_valid", valid_a, 0);
    check("rst_mid_timeout", timeout_a, 0);
    check("rst_mid_dist_a", dist_a, 0);
    check("rst_mid_dist_b", dist_b, 0);
    start = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(5);
    check("post_rst_trig", trig_a, 0);
    check("post_rst_busy", busy_a, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/us_range_meter.md
Name: us_range_meter

Overview:
- Measurement stage for the ultrasonic distance system. Sits directly downstream of the 12 MHz-to-1 MHz clock divider and runs entirely on its 1 MHz output, so one cycle equals 1 us.
- Drives the sensor trigger pulse and times the sensor echo pulse.
- Converts the echo width to centimetres with no hardware divider.
- Presents the result with a one-cycle valid strobe to the display/readout stage.

Parameters:
- TRIG_US, 10: trigger high time, in cycles.
- PERIOD_US, 60000: cycles from one trigger rising edge to the next (measurement repetition period).
- TIMEOUT_US, 30000: maximum cycles in WAIT_HI, and maximum cycles in MEAS.
- US_PER_CM, 58: echo cycles per centimetre.
- CNT_W, 16: width of the general cycle counter. Must hold PERIOD_US.
- DIST_W, 10: width of the distance output.

Ports:
- clk_in, input, 1: 1 MHz clock from the divider.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: level enable. While high, measurements repeat every PERIOD_US.
- echo, input, 1: sensor echo, asynchronous to clk_in.
- trig, output, 1: sensor trigger, registered.
- distance, output, DIST_W: last result in cm, held between measurements.
- valid, output, 1: one-cycle strobe when distance updates.
- timeout, output, 1: set on a failed measurement, cleared on the next valid.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (async, rst=0): state IDLE; trig, valid, timeout, busy, distance, all counters and sync flops reset to 0. Release is used synchronously on the next clk_in edge.
- Echo synchronisation:
  - 2-flop synchroniser feeds echo_s; a third flop gives echo_d.
  - rise = echo_s & ~echo_d; fall = ~echo_s & echo_d.
  - Total latency echo pin to rise/fall detect is 2 cycles.
- IDLE:
  - If start=1, go to TRIG and clear cnt.
  - Otherwise remain in IDLE.
- TRIG:
  - trig=1 for exactly TRIG_US cycles, counted from cycle 0 of the period.
  - Then go to WAIT_HI.
  - cnt keeps counting through the whole period.
- WAIT_HI:
  - Waits for rise. An echo already high on entry does not count as rise; only a low-to-high transition does.
  - On rise: go to MEAS and clear the sub-counter and cm counter.
  - If TIMEOUT_US cycles pass in WAIT_HI with no rise: set timeout=1 and go to HOLDOFF.
- MEAS, each cycle with echo_s=1:
  - sub increments.
  - When sub == US_PER_CM-1, sub wraps to 0 and cm increments.
  - cm saturates at 2^DIST_W-1; no wrap.
- MEAS, on fall:
  - distance <= cm, which equals floor(high_cycles / US_PER_CM).
  - valid=1 for one cycle and timeout<=0.
  - Go to HOLDOFF.
- MEAS, no fall within TIMEOUT_US cycles:
  - timeout=1; distance unchanged; no valid.
  - Go to HOLDOFF.
- HOLDOFF:
  - Wait until cnt == PERIOD_US-1.
  - Then, if start=1, go to TRIG with cnt=0; otherwise go to IDLE.
  - Trigger-to-trigger spacing is exactly PERIOD_US cycles.
- start deasserted mid-measurement: the current cycle completes, including result or timeout. Return to IDLE at the end of HOLDOFF.
- Reset mid-operation: trig drops to 0 immediately (async). No valid is issued.
- fall and the MEAS timeout terminal count in the same cycle: fall wins (valid, timeout=0).
- Parameter legality, with cnt counting from period start (TRIG start) and wrapping at PERIOD_US:
  - TRIG_US + 2*TIMEOUT_US < PERIOD_US.
  - The pair must still fit in the period with enough margin that the exit from WAIT_HI or MEAS always lands before cnt reaches PERIOD_US-1.
  - Defaults: 10 + 2*30000 = 60010 does not satisfy 60010 < 60000. Override one value at instantiation, e.g. PERIOD_US=65000 with CNT_W=16, or TIMEOUT_US=29000.
  - Implementation checks legality with an elaboration-time error.

Decomposition:
- Shared package us_range_pkg:
  - State enum: IDLE, TRIG, WAIT_HI, MEAS, HOLDOFF.
  - Default timing constants: TRIG_US, PERIOD_US, TIMEOUT_US, US_PER_CM.
  - The 12 MHz / 1 MHz ratio constant, also used by the divider.
- One sub-module: us_echo_sync. It holds the 2-flop synchroniser plus edge detect, outputs echo_s/rise/fall, and is reused by any other async sensor input.
- The FSM, counters and cm accumulation stay in the top module.

Test Plan:
- Reset, then start=1: trig high exactly cycles 0..9 after leaving IDLE, busy=1. Next trig rise exactly PERIOD_US cycles later.
- Echo rise 500 cycles after trig falls, high 580 cycles: distance=10, a single valid pulse 2 to 3 cycles after echo falls, timeout=0.
- Echo high 57 cycles gives distance=0; 58 gives 1; 116 gives 2. Verifies the floor at the sub-counter wrap boundary.
- Echo never rises: timeout=1 after TIMEOUT_US cycles in WAIT_HI, no valid, previous distance held. A following good 1160-cycle echo clears timeout and gives distance=20.
- DIST_W=4 with echo held high for 1200 cycles: distance saturates at 15. Echo stuck high beyond TIMEOUT_US: timeout=1.
- start dropped during MEAS: result still reported, then IDLE, no further trig. rst pulsed during TRIG: trig=0 asynchronously, all outputs 0.
